writeback_stage: RTL and testbench

- Final pipeline stage. Takes retiring instructions from the memory stage, selects and formats the result, and drives the register-file write port (rd address, data, write enable) that the decode stage's register file samples.
- Owns load completion: aligns and sign/zero-extends load data, waits for a late load acknowledge, and stalls upstream while waiting.
- Converts malformed, misaligned or timed-out loads into an exception pulse.

---
 rtl/writeback_stage_pkg.sv | 30 +++
 rtl/writeback_stage_load_formatter.sv | 44 ++++
 rtl/writeback_stage.sv | 177 +++++++++++++++++
 tb/tb_writeback_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared opcode-class and load-funct3 encodings for the pipeline.
// Imported by the writeback stage and its load formatter.
package writeback_stage_pkg;

  localparam int OPCODE_WIDTH = 11;

  localparam int OP_RTYPE  = 0;
  localparam int OP_ITYPE  = 1;
  localparam int OP_LOAD   = 2;
  localparam int OP_STORE  = 3;
  localparam int OP_BRANCH = 4;
  localparam int OP_JAL    = 5;
  localparam int OP_JALR   = 6;
  localparam int OP_LUI    = 7;
  localparam int OP_AUIPC  = 8;
  localparam int OP_SYSTEM = 9;
  localparam int OP_FENCE  = 10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    S_IDLE,
    S_WAIT_LOAD
  } wb_state_t;

endpackage

// File: rtl/writeback_stage_load_formatter.sv
// Combinational load aligner/extender with misalignment and
// bad-funct3 fault detection; shared with the memory stage.
module writeback_stage_load_formatter
  import writeback_stage_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int FUNCT_WIDTH = 3
) (
  input  logic [DWIDTH-1:0]      data,
  input  logic [FUNCT_WIDTH-1:0] funct3,
  input  logic [1:0]             offset,
  output logic [DWIDTH-1:0]      fmt_data,
  output logic                   fault
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = data[{offset, 3'b000} +: 8];
  assign half_v = data[{offset[1], 4'b0000} +: 16];

  always_comb begin
    fmt_data = '0;
    fault    = 1'b0;
    unique case (funct3)
      F3_LB:  fmt_data = {{(DWIDTH-8){byte_v[7]}}, byte_v};
      F3_LBU: fmt_data = {{(DWIDTH-8){1'b0}}, byte_v};
      F3_LH: begin
        fmt_data = {{(DWIDTH-16){half_v[15]}}, half_v};
        fault    = offset[0];
      end
      F3_LHU: begin
        fmt_data = {{(DWIDTH-16){1'b0}}, half_v};
        fault    = offset[0];
      end
      F3_LW: begin
        fmt_data = data;
        fault    = |offset;
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: selects the result, completes loads and
// drives the register-file write port.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DWIDTH       = 32,
  parameter int AWIDTH       = 5,
  parameter int PC_WIDTH     = 32,
  parameter int FUNCT_WIDTH  = 3,
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic                    ws_clk,
  input  logic                    ws_rst,
  input  logic                    ws_i_ce,
  input  logic [OPCODE_WIDTH-1:0] ws_i_opcode,
  input  logic [FUNCT_WIDTH-1:0]  ws_i_funct3,
  input  logic [AWIDTH-1:0]       ws_i_addr_rd,
  input  logic [DWIDTH-1:0]       ws_i_alu_result,
  input  logic [PC_WIDTH-1:0]     ws_i_pc,
  input  logic [DWIDTH-1:0]       ws_i_load_data,
  input  logic                    ws_i_load_ack,
  input  logic                    ws_i_flush,
  output logic                    ws_o_we,
  output logic [AWIDTH-1:0]       ws_o_addr_rd,
  output logic [DWIDTH-1:0]       ws_o_data_rd,
  output logic [PC_WIDTH-1:0]     ws_o_pc,
  output logic                    ws_o_ce,
  output logic                    ws_o_stall,
  output logic                    ws_o_flush,
  output logic                    ws_o_exception
);

  localparam int CW = $clog2(LOAD_TIMEOUT + 1);

  wb_state_t state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [AWIDTH-1:0]      cap_rd;
  logic [FUNCT_WIDTH-1:0] cap_f3;
  logic [1:0]             cap_off;
  logic [PC_WIDTH-1:0]    cap_pc;

  logic                   idle, is_load, capture;
  logic                   retire, wr, exc;
  logic [AWIDTH-1:0]      rd_sel;
  logic [PC_WIDTH-1:0]    pc_sel, pc_inc;
  logic [FUNCT_WIDTH-1:0] f3_sel;
  logic [1:0]             off_sel;
  logic [DWIDTH-1:0]      fmt_data, res;
  logic                   fault;

  assign idle    = (state == S_IDLE);
  assign is_load = ws_i_opcode[OP_LOAD];
  assign rd_sel  = idle ? ws_i_addr_rd : cap_rd;
  assign pc_sel  = idle ? ws_i_pc : cap_pc;
  assign f3_sel  = idle ? ws_i_funct3 : cap_f3;
  assign off_sel = idle ? ws_i_alu_result[1:0] : cap_off;
  assign pc_inc  = pc_sel + PC_WIDTH'(4);

  assign ws_o_stall = (!idle && !ws_i_load_ack)
                    | (idle && ws_i_ce && is_load && !ws_i_load_ack);

  writeback_stage_load_formatter #(
    .DWIDTH      (DWIDTH),
    .FUNCT_WIDTH (FUNCT_WIDTH)
  ) u_fmt (
    .data     (ws_i_load_data),
    .funct3   (f3_sel),
    .offset   (off_sel),
    .fmt_data (fmt_data),
    .fault    (fault)
  );

  always_comb begin
    res = ws_i_alu_result;
    if (!idle) begin
      res = fmt_data;
    end else begin
      unique case (1'b1)
        ws_i_opcode[OP_LOAD]: res = fmt_data;
        ws_i_opcode[OP_JAL],
        ws_i_opcode[OP_JALR]: res = DWIDTH'(pc_inc);
        default:              res = ws_i_alu_result;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    retire  = 1'b0;
    wr      = 1'b0;
    exc     = 1'b0;
    capture = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (ws_i_ce && !ws_i_flush) begin
          if (!is_load) begin
            retire = 1'b1;
            wr     = ws_i_opcode[OP_RTYPE] | ws_i_opcode[OP_ITYPE]
                   | ws_i_opcode[OP_LUI]   | ws_i_opcode[OP_AUIPC]
                   | ws_i_opcode[OP_JAL]   | ws_i_opcode[OP_JALR];
          end else if (ws_i_load_ack) begin
            retire = 1'b1;
            wr     = !fault;
            exc    = fault;
          end else begin
            capture = 1'b1;
            cnt_n   = '0;
            state_n = S_WAIT_LOAD;
          end
        end
      end
      S_WAIT_LOAD: begin
        cnt_n = cnt + 1'b1;
        if (ws_i_flush) begin
          cnt_n   = '0;
          state_n = S_IDLE;
        end else if (ws_i_load_ack) begin
          retire  = 1'b1;
          wr      = !fault;
          exc     = fault;
          cnt_n   = '0;
          state_n = S_IDLE;
        end else if (cnt == CW'(LOAD_TIMEOUT - 1)) begin
          exc     = 1'b1;
          cnt_n   = '0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge ws_clk or posedge ws_rst) begin
    if (ws_rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      cap_rd  <= '0;
      cap_f3  <= '0;
      cap_off <= '0;
      cap_pc  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (capture) begin
        cap_rd  <= ws_i_addr_rd;
        cap_f3  <= ws_i_funct3;
        cap_off <= ws_i_alu_result[1:0];
        cap_pc  <= ws_i_pc;
      end
    end
  end

  // rd==0 still retires but never writes x0
  always_ff @(posedge ws_clk or posedge ws_rst) begin
    if (ws_rst) begin
      ws_o_we        <= 1'b0;
      ws_o_ce        <= 1'b0;
      ws_o_exception <= 1'b0;
      ws_o_flush     <= 1'b0;
      ws_o_addr_rd   <= '0;
      ws_o_data_rd   <= '0;
      ws_o_pc        <= '0;
    end else begin
      ws_o_we        <= wr && (rd_sel != '0);
      ws_o_ce        <= retire;
      ws_o_exception <= exc;
      ws_o_flush     <= ws_i_flush;
      if (retire) begin
        ws_o_addr_rd <= rd_sel;
        ws_o_data_rd <= res;
        ws_o_pc      <= pc_sel;
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage.
// Inputs change on negedge; registered outputs sampled #1 after posedge.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_ce;
  logic [10:0] i_op;
  logic [2:0]  i_f3;
  logic [4:0]  i_rd;
  logic [31:0] i_alu;
  logic [31:0] i_pc;
  logic [31:0] i_ld;
  logic        i_ack;
  logic        i_flush;
  logic        o_we;
  logic [4:0]  o_rd;
  logic [31:0] o_data;
  logic [31:0] o_pc;
  logic        o_ce;
  logic        o_stall;
  logic        o_flush;
  logic        o_exc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  writeback_stage #(
    .LOAD_TIMEOUT (8)
  ) dut (
    .ws_clk          (clk),
    .ws_rst          (rst),
    .ws_i_ce         (i_ce),
    .ws_i_opcode     (i_op),
    .ws_i_funct3     (i_f3),
    .ws_i_addr_rd    (i_rd),
    .ws_i_alu_result (i_alu),
    .ws_i_pc         (i_pc),
    .ws_i_load_data  (i_ld),
    .ws_i_load_ack   (i_ack),
    .ws_i_flush      (i_flush),
    .ws_o_we         (o_we),
    .ws_o_addr_rd    (o_rd),
    .ws_o_data_rd    (o_data),
    .ws_o_pc         (o_pc),
    .ws_o_ce         (o_ce),
    .ws_o_stall      (o_stall),
    .ws_o_flush      (o_flush),
    .ws_o_exception  (o_exc)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ce, input int opb, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] pc, input logic [31:0] ld,
                       input logic ack);
    @(negedge clk);
    i_ce  = ce;
    i_op  = 11'(1) << opb;
    i_f3  = f3;
    i_rd  = rd;
    i_alu = alu;
    i_pc  = pc;
    i_ld  = ld;
    i_ack = ack;
    i_flush = 1'b0;
    #1;
  endtask

  task automatic idle_in();
    @(negedge clk);
    i_ce = 1'b0;
    i_ack = 1'b0;
    i_flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    i_ce = 0; i_op = 0; i_f3 = 0; i_rd = 0; i_alu = 0;
    i_pc = 0; i_ld = 0; i_ack = 0; i_flush = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 64'(o_we), 0);
    chk("rst_ce", 64'(o_ce), 0);
    chk("rst_exc", 64'(o_exc), 0);
    chk("rst_data", 64'(o_data), 0);
    chk("rst_rd", 64'(o_rd), 0);
    chk("rst_pc", 64'(o_pc), 0);
    chk("rst_stall", 64'(o_stall), 0);
    chk("rst_flush", 64'(o_flush), 0);
    @(negedge clk);
    rst = 1'b0;

    // ITYPE rd=5
    drive(1, OP_ITYPE, 3'b000, 5, 32'h0000_1234, 32'h40, 0, 0);
    step();
    chk("itype_we", 64'(o_we), 1);
    chk("itype_rd", 64'(o_rd), 5);
    chk("itype_data", 64'(o_data), 64'h1234);
    chk("itype_ce", 64'(o_ce), 1);
    idle_in();
    step();
    chk("itype_we_pulse", 64'(o_we), 0);
    chk("itype_ce_pulse", 64'(o_ce), 0);
    chk("itype_hold", 64'(o_data), 64'h1234);

    // JAL rd=1
    drive(1, OP_JAL, 3'b000, 1, 32'h9999, 32'h0000_0100, 0, 0);
    step();
    chk("jal_data", 64'(o_data), 64'h104);
    chk("jal_we", 64'(o_we), 1);
    chk("jal_pc", 64'(o_pc), 64'h100);

    // LB offset 2, ack same cycle
    drive(1, OP_LOAD, F3_LB, 3, 32'h0000_2002, 0, 32'h1180_FF00, 1);
    chk("lb_stall", 64'(o_stall), 0);
    step();
    chk("lb_data", 64'(o_data), 64'hFFFF_FF80);
    chk("lb_we", 64'(o_we), 1);

    // LHU offset 2
    drive(1, OP_LOAD, F3_LHU, 4, 32'h0000_2002, 0, 32'h1180_FF00, 1);
    step();
    chk("lhu_data", 64'(o_data), 64'h0000_1180);
    chk("lhu_rd", 64'(o_rd), 4);

    // LW with late ack
    drive(1, OP_LOAD, F3_LW, 7, 32'h0000_3000, 32'h200, 0, 0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("lw_stall_c%0d", c), 64'(o_stall), 1);
      step();
      chk($sformatf("lw_we_c%0d", c), 64'(o_we), 0);
    end
    @(negedge clk);
    i_ld = 32'hDEAD_BEEF;
    i_ack = 1'b1;
    #1;
    chk("lw_stall_ack", 64'(o_stall), 0);
    step();
    chk("lw_data", 64'(o_data), 64'hDEAD_BEEF);
    chk("lw_we", 64'(o_we), 1);
    chk("lw_rd", 64'(o_rd), 7);
    chk("lw_pc", 64'(o_pc), 64'h200);
    idle_in();

    // LH misaligned
    drive(1, OP_LOAD, F3_LH, 6, 32'h0000_0001, 0, 32'h1234_5678, 1);
    step();
    chk("lh_mis_exc", 64'(o_exc), 1);
    chk("lh_mis_we", 64'(o_we), 0);
    chk("lh_mis_ce", 64'(o_ce), 1);

    // timeout after 8 wait cycles
    drive(1, OP_LOAD, F3_LW, 8, 32'h0000_0000, 0, 0, 0);
    step();
    idle_in();
    for (int c = 1; c <= 7; c++) begin
      step();
      chk($sformatf("to_noexc_%0d", c), 64'(o_exc), 0);
    end
    chk("to_stall_w8", 64'(o_stall), 1);
    step();
    chk("to_exc", 64'(o_exc), 1);
    chk("to_we", 64'(o_we), 0);
    chk("to_stall_rel", 64'(o_stall), 0);

    // RTYPE rd=0
    drive(1, OP_RTYPE, 3'b000, 0, 32'hABCD, 0, 0, 0);
    step();
    chk("x0_ce", 64'(o_ce), 1);
    chk("x0_we", 64'(o_we), 0);

    // flush on ack cycle
    drive(1, OP_LOAD, F3_LW, 9, 32'h0000_0000, 0, 0, 0);
    step();
    @(negedge clk);
    i_ce = 1'b0;
    i_ack = 1'b1;
    i_flush = 1'b1;
    i_ld = 32'h5555_AAAA;
    step();
    chk("fl_we", 64'(o_we), 0);
    chk("fl_exc", 64'(o_exc), 0);
    chk("fl_ce", 64'(o_ce), 0);
    chk("fl_oflush", 64'(o_flush), 1);
    idle_in();
    step();
    chk("fl_idle_stall", 64'(o_stall), 0);

    // reset mid-wait
    drive(1, OP_LOAD, F3_LW, 10, 32'h0000_0000, 0, 0, 0);
    step();
    idle_in();
    #1;
    chk("rw_stall_pre", 64'(o_stall), 1);
    rst = 1'b1;
    #1;
    chk("rw_stall", 64'(o_stall), 0);
    chk("rw_we", 64'(o_we), 0);
    chk("rw_data", 64'(o_data), 0);
    chk("rw_flush", 64'(o_flush), 0);
    @(negedge clk);
    rst = 1'b0;
    i_ack = 1'b1;
    i_ld = 32'h1111_2222;
    step();
    chk("rw_no_write", 64'(o_we), 0);
    chk("rw_no_ce", 64'(o_ce), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
